// File: rtl/image_regs_axi.sv
// image_regs_axi: AXI4-Lite register bank for an image pipeline.
// NUM_CTRL read/write control words drive ctrl_out, and NUM_STAT read-only
// words mirror stat_in. A write commit pulses wr_pulse for the written word.
// Optional macro SHADOW_UPDATE_EN: ctrl_out becomes a shadow copy that is
// reloaded from the control registers only on frame_start.
//
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where VALID and READY are both high. A source holds VALID and its payload
// until that edge. READY never depends on VALID on the same channel.
module image_regs_axi #(
    parameter int NUM_CTRL = 4,
    parameter int NUM_STAT = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6
) (
    input  logic                                           ACLK,
    input  logic                                           ARESET,
    input  logic [ADDR_W-1:0]                              AWADDR,
    input  logic                                           AWVALID,
    output logic                                           AWREADY,
    input  logic [DATA_W-1:0]                              WDATA,
    input  logic [DATA_W/8-1:0]                            WSTRB,
    input  logic                                           WVALID,
    output logic                                           WREADY,
    output logic [1:0]                                     BRESP,
    output logic                                           BVALID,
    input  logic                                           BREADY,
    input  logic [ADDR_W-1:0]                              ARADDR,
    input  logic                                           ARVALID,
    output logic                                           ARREADY,
    output logic [DATA_W-1:0]                              RDATA,
    output logic [1:0]                                     RRESP,
    output logic                                           RVALID,
    input  logic                                           RREADY,
    input  logic                                           frame_start,
    output logic [NUM_CTRL*DATA_W-1:0]                     ctrl_out,
    input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*DATA_W-1:0] stat_in,
    output logic [NUM_CTRL-1:0]                            wr_pulse,
    output logic                                           dbg_w_state,
    output logic                                           dbg_r_state
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t               w_state_q, w_state_d;
    logic                   aw_have_q, aw_have_d;
    logic                   w_have_q, w_have_d;
    logic [IDX_W-1:0]       aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]      w_data_q, w_data_d;
    logic [STRB_W-1:0]      w_strb_q, w_strb_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [DATA_W-1:0]      ctrl_q [NUM_CTRL];
    logic [DATA_W-1:0]      ctrl_d [NUM_CTRL];

    r_state_t               r_state_q, r_state_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;

    logic                   aw_hs;
    logic                   w_hs;
    logic                   ar_hs;
    logic                   commit;
    logic [IDX_W-1:0]       ar_idx;
    logic [NUM_CTRL*DATA_W-1:0] ctrl_flat;
    logic                   unused_inputs;

    // Each write half is offered only while idle and not yet captured;
    // readiness is held low throughout reset.
    assign AWREADY = !ARESET && (w_state_q == W_IDLE) && !aw_have_q;
    assign WREADY  = !ARESET && (w_state_q == W_IDLE) && !w_have_q;
    assign ARREADY = !ARESET && (r_state_q == R_IDLE);
    assign BVALID  = (w_state_q == W_RESP);
    assign BRESP   = bresp_q;
    assign RVALID  = (r_state_q == R_DATA);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign commit = !ARESET && (w_state_q == W_IDLE) && aw_have_q && w_have_q;
    assign ar_idx = ARADDR[ADDR_W-1:LSB];

    assign dbg_w_state = w_state_q;
    assign dbg_r_state = r_state_q;

    // Write path: capture AW and W independently, commit once both are held.
    always_comb begin
        w_state_d = w_state_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        aw_idx_d  = aw_idx_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        wr_pulse  = '0;
        case (w_state_q)
            W_IDLE: begin
                if (commit) begin
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    w_state_d = W_RESP;
                    bresp_d   = RESP_SLVERR;
                    for (int k = 0; k < NUM_CTRL; k++) begin
                        if (int'(aw_idx_q) == k) begin
                            for (int b = 0; b < STRB_W; b++) begin
                                if (w_strb_q[b]) begin
                                    ctrl_d[k][b*8 +: 8] = w_data_q[b*8 +: 8];
                                end
                            end
                            wr_pulse[k] = 1'b1;
                            bresp_d     = RESP_OKAY;
                        end
                    end
                end else begin
                    if (aw_hs) begin
                        aw_have_d = 1'b1;
                        aw_idx_d  = AWADDR[ADDR_W-1:LSB];
                    end
                    if (w_hs) begin
                        w_have_d = 1'b1;
                        w_data_d = WDATA;
                        w_strb_d = WSTRB;
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write path state and control register storage.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            for (int k = 0; k < NUM_CTRL; k++) begin
                ctrl_q[k] <= '0;
            end
        end else begin
            w_state_q <= w_state_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            aw_idx_q  <= aw_idx_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
            for (int k = 0; k < NUM_CTRL; k++) begin
                ctrl_q[k] <= ctrl_d[k];
            end
        end
    end

    // Read path: sample the addressed word on the AR handshake, so a same-cycle
    // commit is seen only by later reads.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rdata_d   = '0;
                    rresp_d   = RESP_SLVERR;
                    for (int k = 0; k < NUM_CTRL; k++) begin
                        if (int'(ar_idx) == k) begin
                            rdata_d = ctrl_q[k];
                            rresp_d = RESP_OKAY;
                        end
                    end
                    for (int k = 0; k < NUM_STAT; k++) begin
                        if (int'(ar_idx) == NUM_CTRL + k) begin
                            rdata_d = stat_in[k*DATA_W +: DATA_W];
                            rresp_d = RESP_OKAY;
                        end
                    end
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read path state and registered response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Flatten the control registers into the packed output layout.
    always_comb begin
        ctrl_flat = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            ctrl_flat[k*DATA_W +: DATA_W] = ctrl_q[k];
        end
    end

`ifdef SHADOW_UPDATE_EN
    logic [NUM_CTRL*DATA_W-1:0] shadow_q, shadow_d;

    // Image logic sees new settings only at frame boundaries.
    always_comb begin
        shadow_d = shadow_q;
        if (frame_start) begin
            shadow_d = ctrl_flat;
        end
    end

    // Shadow copy register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign ctrl_out      = shadow_q;
    assign unused_inputs = ^{AWADDR[LSB-1:0], ARADDR[LSB-1:0]};
`else
    assign ctrl_out      = ctrl_flat;
    assign unused_inputs = ^{frame_start, AWADDR[LSB-1:0], ARADDR[LSB-1:0]};
`endif

endmodule
